// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and FSM state type for the 8N1 UART
//                receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz system clock / 9600 baud
    localparam int c_CLKS_PER_BIT_DEFAULT = 5208;

    // 8N1 frame: 8 data bits, no parity, 1 stop bit
    localparam int c_DATA_BITS = 8;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1 serial receiver: 2-FF input synchronizer, framing FSM
//                and LSB-first shift register. Emits one-cycle good-byte and
//                framing-error strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx,
    output logic [c_DATA_BITS-1:0] o_data,
    output logic                   o_valid,
    output logic                   o_err,
    output logic                   o_busy
);

    localparam int                 c_CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int                 c_BIT_W      = $clog2(c_DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA  = c_BIT_W'(c_DATA_BITS - 1);

    logic                   r_rx_meta;
    logic                   r_rx_s;
    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [c_CNT_W-1:0]     r_clk_cnt;
    logic [c_CNT_W-1:0]     w_clk_cnt_next;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [c_BIT_W-1:0]     w_bit_cnt_next;
    logic [c_DATA_BITS-1:0] r_shift;
    logic [c_DATA_BITS-1:0] w_shift_next;
    logic                   r_valid;
    logic                   w_valid_next;
    logic                   r_err;
    logic                   w_err_next;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State, counters, shift register and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
        end
    end

    // Next-state logic: every sample lands at a bit centre after the edge
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt + 1'b1;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_valid_next   = 1'b0;
        w_err_next     = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                if (!r_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    // A line already back high at mid-start was only a glitch
                    w_state_next   = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {r_rx_s, r_shift[c_DATA_BITS-1:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_LAST_DATA) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_next = '0;
                    // Leaving at the stop centre lets a directly following start edge be caught
                    if (r_rx_s) begin
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                w_clk_cnt_next = '0;
                if (r_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
            end
        endcase
    end

    assign o_data  = r_shift;
    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_busy  = (r_state != IDLE);

endmodule : uart_rx_core
`default_nettype wire

// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_capture
//  Description : 8N1 UART receiver with a 3-deep history of the most recent
//                good bytes (byte0 = newest), feeding the hex display.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte0,
    output logic [7:0] byte1,
    output logic [7:0] byte2,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    logic [7:0] w_core_data;
    logic       w_core_valid;
    logic       w_core_err;
    logic       w_core_busy;

    logic [7:0] r_byte0;
    logic [7:0] r_byte1;
    logic [7:0] r_byte2;
    logic       r_rx_valid;
    logic       r_frame_err;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (rx),
        .o_data  (w_core_data),
        .o_valid (w_core_valid),
        .o_err   (w_core_err),
        .o_busy  (w_core_busy)
    );

    // History shift on each good byte; strobes re-timed to line up with the update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte0     <= 8'h00;
            r_byte1     <= 8'h00;
            r_byte2     <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_core_valid;
            r_frame_err <= w_core_err;
            if (w_core_valid) begin
                r_byte2 <= r_byte1;
                r_byte1 <= r_byte0;
                r_byte0 <= w_core_data;
            end
        end
    end

    assign byte0     = r_byte0;
    assign byte1     = r_byte1;
    assign byte2     = r_byte2;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = w_core_busy;

endmodule : uart_rx_capture
`default_nettype wire
